// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: valid/ready request and response
// handshakes, programmable wait states, sub-word access with load extension, and error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  DM_4,
    output logic [7:0]  DM_12
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                          state;
    logic [3:0]                      count;
    logic [DEPTH_WORDS-1:0][31:0]    mem;

    logic                            write_q;
    logic [IDX_W+1:0]                addr_q;
    logic [1:0]                      size_q;
    logic                            unsigned_q;
    logic [31:0]                     wdata_q;

    logic                            req_err;
    logic                            acc_write;
    logic                            acc_unsigned;
    logic [1:0]                      acc_size;
    logic [IDX_W+1:0]                acc_addr;
    logic [31:0]                     acc_wdata;
    logic [1:0]                      lane;
    logic [31:0]                     cur_word;
    logic [31:0]                     store_word;
    logic [31:0]                     load_data;
    logic [7:0]                      sel_byte;
    logic [15:0]                     sel_half;

    assign req_ready = (state == S_IDLE);
    assign DM_4      = mem[1][7:0];
    assign DM_12     = mem[3][7:0];

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                          req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])           req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) req_err = 1'b1;
    end

    // With no wait states the access happens on the accept edge, so it must see the live request.
    always_comb begin
        if (state == S_IDLE) begin
            acc_write    = req_write;
            acc_unsigned = req_unsigned;
            acc_size     = req_size;
            acc_addr     = req_addr[IDX_W+1:0];
            acc_wdata    = req_wdata;
        end else begin
            acc_write    = write_q;
            acc_unsigned = unsigned_q;
            acc_size     = size_q;
            acc_addr     = addr_q;
            acc_wdata    = wdata_q;
        end
    end

    always_comb begin
        lane       = acc_addr[1:0];
        cur_word   = mem[acc_addr[IDX_W+1:2]];
        store_word = cur_word;
        sel_byte   = cur_word[{lane, 3'b000} +: 8];
        sel_half   = cur_word[{lane[1], 4'b0000} +: 16];
        load_data  = cur_word;
        unique case (acc_size)
            2'b00: begin
                store_word[{lane, 3'b000} +: 8] = acc_wdata[7:0];
                load_data = {{24{sel_byte[7] & ~acc_unsigned}}, sel_byte};
            end
            2'b01: begin
                store_word[{lane[1], 4'b0000} +: 16] = acc_wdata[15:0];
                load_data = {{16{sel_half[15] & ~acc_unsigned}}, sel_half};
            end
            default: begin
                store_word = acc_wdata;
                load_data  = cur_word;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            // NOTE: storage is a register array, not a RAM macro, so it can be cleared on reset.
            mem        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        addr_q     <= req_addr[IDX_W+1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= S_RESP;
                        end else if (WAIT_STATES == 0) begin
                            if (acc_write) begin
                                mem[acc_addr[IDX_W+1:2]] <= store_word;
                                rsp_rdata <= '0;
                            end else begin
                                rsp_rdata <= load_data;
                            end
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            count <= 4'(WAIT_STATES - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (count == 4'd0) begin
                        if (acc_write) begin
                            mem[acc_addr[IDX_W+1:2]] <= store_word;
                            rsp_rdata <= '0;
                        end else begin
                            rsp_rdata <= load_data;
                        end
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a byte-array reference model checked every cycle on the main
// instance (2 wait states), plus directed checks on 0- and 3-wait-state instances.
module tb_dmem_responder;

    localparam int WS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_write, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  dm_4, dm_12;

    logic        reset_z, req_valid_z, req_write_z, req_unsigned_z, rsp_ready_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [1:0]  req_size_z;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;
    logic [7:0]  dm_4_z, dm_12_z;

    logic        reset_t, req_valid_t, req_write_t, req_unsigned_t, rsp_ready_t;
    logic [31:0] req_addr_t, req_wdata_t;
    logic [1:0]  req_size_t;
    logic        req_ready_t, rsp_valid_t, rsp_err_t;
    logic [31:0] rsp_rdata_t;
    logic [7:0]  dm_4_t, dm_12_t;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .DM_4(dm_4), .DM_12(dm_12)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_z (
        .clk(clk), .reset(reset_z), .req_valid(req_valid_z), .req_ready(req_ready_z),
        .req_write(req_write_z), .req_addr(req_addr_z), .req_size(req_size_z),
        .req_unsigned(req_unsigned_z), .req_wdata(req_wdata_z), .rsp_valid(rsp_valid_z),
        .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z),
        .DM_4(dm_4_z), .DM_12(dm_12_z)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut_t (
        .clk(clk), .reset(reset_t), .req_valid(req_valid_t), .req_ready(req_ready_t),
        .req_write(req_write_t), .req_addr(req_addr_t), .req_size(req_size_t),
        .req_unsigned(req_unsigned_t), .req_wdata(req_wdata_t), .rsp_valid(rsp_valid_t),
        .rsp_ready(rsp_ready_t), .rsp_rdata(rsp_rdata_t), .rsp_err(rsp_err_t),
        .DM_4(dm_4_t), .DM_12(dm_12_t)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Reference model: byte-addressed storage and an outstanding-transaction countdown.
    logic [7:0]  m [1024];
    bit          live = 1'b0, busy = 1'b0, responding = 1'b0;
    int          lat_left;
    logic        m_w, m_u;
    logic [1:0]  m_sz;
    logic [31:0] m_a, m_wd;
    logic [31:0] exp_data = '0;
    logic        exp_err  = 1'b0;

    function automatic bit illegal(input logic [31:0] a, input logic [1:0] sz);
        int n;
        if (sz == 2'b11) return 1'b1;
        n = 1 << sz;
        return (a >= 32'd1024) || ((a % n) != 0);
    endfunction

    task automatic model_access();
        int n;
        logic [31:0] v;
        n = 1 << m_sz;
        if (m_w) begin
            for (int i = 0; i < n; i++) m[m_a + i] = m_wd[8*i +: 8];
            exp_data = '0;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(m[m_a + i]) << (8 * i));
            if (!m_u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            exp_data = v;
        end
        exp_err = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            live = 1'b1; busy = 1'b0; responding = 1'b0;
            exp_data = '0; exp_err = 1'b0;
            foreach (m[i]) m[i] = 8'h00;
        end else if (live) begin
            if (!busy) begin
                if (req_valid) begin
                    busy = 1'b1;
                    m_w = req_write; m_u = req_unsigned; m_sz = req_size;
                    m_a = req_addr;  m_wd = req_wdata;
                    if (illegal(m_a, m_sz)) begin
                        responding = 1'b1; exp_err = 1'b1; exp_data = '0;
                    end else begin
                        lat_left = WS;
                        if (lat_left == 0) begin
                            model_access();
                            responding = 1'b1;
                        end
                    end
                end
            end else if (responding) begin
                if (rsp_ready) begin
                    busy = 1'b0; responding = 1'b0; exp_data = '0; exp_err = 1'b0;
                end
            end else begin
                lat_left--;
                if (lat_left == 0) begin
                    model_access();
                    responding = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check1("req_ready", req_ready, !busy);
            check1("rsp_valid", rsp_valid, responding);
            check("rsp_rdata", rsp_rdata, exp_data);
            check1("rsp_err", rsp_err, exp_err);
            check("dm_4", {24'b0, dm_4}, {24'b0, m[4]});
            check("dm_12", {24'b0, dm_12}, {24'b0, m[12]});
        end
    end

    task automatic transact(input logic w, input logic [31:0] a, input logic [1:0] sz,
                            input logic u, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
        req_unsigned = u; req_wdata = wd; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        if (lat >= 40) check("response_timeout", 32'(lat), 32'd0);
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, n;

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd4;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0000_00AA; rsp_ready = 1'b0;
        reset_z = 1'b1; req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0;
        req_size_z = 2'b10; req_unsigned_z = 1'b0; req_wdata_z = '0; rsp_ready_z = 1'b0;
        reset_t = 1'b1; req_valid_t = 1'b0; req_write_t = 1'b0; req_addr_t = '0;
        req_size_t = 2'b10; req_unsigned_t = 1'b0; req_wdata_t = '0; rsp_ready_t = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; reset_z = 1'b0; reset_t = 1'b0;
        @(negedge clk);
        check1("rst_req_ready", req_ready, 1'b1);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_dm_4", {24'b0, dm_4}, 32'h0);
        check("rst_dm_12", {24'b0, dm_12}, 32'h0);

        transact(1'b1, 32'd4, 2'b10, 1'b0, 32'h8000_00A5, rd, er, lat);
        check("st_w4_latency", 32'(lat), 32'd3);
        check1("st_w4_err", er, 1'b0);
        check("st_w4_dm_4", {24'b0, dm_4}, 32'hA5);
        transact(1'b0, 32'd4, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("ld_w4", rd, 32'h8000_00A5);

        transact(1'b1, 32'd12, 2'b10, 1'b0, 32'h1122_3344, rd, er, lat);
        check("st_w12_dm_12", {24'b0, dm_12}, 32'h44);
        transact(1'b1, 32'd13, 2'b00, 1'b0, 32'hABCD_EFFF, rd, er, lat);
        check("st_b13_dm_12", {24'b0, dm_12}, 32'h44);
        transact(1'b0, 32'd12, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("ld_w12_merged", rd, 32'h1122_FF44);
        transact(1'b0, 32'd13, 2'b00, 1'b0, 32'h0, rd, er, lat);
        check("ld_b13_signed", rd, 32'hFFFF_FFFF);
        transact(1'b0, 32'd13, 2'b00, 1'b1, 32'h0, rd, er, lat);
        check("ld_b13_unsigned", rd, 32'h0000_00FF);
        transact(1'b0, 32'd14, 2'b01, 1'b0, 32'h0, rd, er, lat);
        check("ld_h14_signed", rd, 32'h0000_1122);
        transact(1'b0, 32'd12, 2'b01, 1'b0, 32'h0, rd, er, lat);
        check("ld_h12_signed", rd, 32'hFFFF_FF44);

        transact(1'b1, 32'd6, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
        check1("err_w6_err", er, 1'b1);
        check("err_w6_latency", 32'(lat), 32'd1);
        transact(1'b0, 32'd4, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("err_w6_unchanged", rd, 32'h8000_00A5);
        transact(1'b0, 32'd3, 2'b01, 1'b0, 32'h0, rd, er, lat);
        check1("err_h3_err", er, 1'b1);
        check("err_h3_rdata", rd, 32'h0);
        transact(1'b0, 32'd0, 2'b11, 1'b0, 32'h0, rd, er, lat);
        check1("err_size11", er, 1'b1);
        transact(1'b1, 32'h400, 2'b00, 1'b0, 32'h0000_0077, rd, er, lat);
        check1("err_range_err", er, 1'b1);
        transact(1'b0, 32'd0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("err_range_nowrap", rd, 32'h0);

        // Backpressure with a second request pending behind the response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd12; req_size = 2'b10; req_unsigned = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_addr = 32'd4; req_size = 2'b00; req_unsigned = 1'b1;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("bp_timeout", 32'(n), 32'd0);
        repeat (5) begin
            check1("bp_valid", rsp_valid, 1'b1);
            check("bp_rdata", rsp_rdata, 32'h1122_FF44);
            check1("bp_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check1("bp_ready_after", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_pending_latency", 32'(n), 32'd3);
        check("bp_pending_rdata", rsp_rdata, 32'h0000_00A5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Zero wait states: response in the cycle right after accept.
        @(negedge clk);
        check1("z_ready", req_ready_z, 1'b1);
        req_valid_z = 1'b1; req_write_z = 1'b1; req_addr_z = 32'd4; req_wdata_z = 32'h1234_5678;
        @(negedge clk);
        req_valid_z = 1'b0;
        check1("z_st_valid", rsp_valid_z, 1'b1);
        check1("z_st_err", rsp_err_z, 1'b0);
        check("z_st_dm_4", {24'b0, dm_4_z}, 32'h78);
        check("z_st_dm_12", {24'b0, dm_12_z}, 32'h0);
        rsp_ready_z = 1'b1;
        @(negedge clk);
        rsp_ready_z = 1'b0;
        check1("z_ready_after", req_ready_z, 1'b1);
        req_valid_z = 1'b1; req_write_z = 1'b0;
        @(negedge clk);
        req_valid_z = 1'b0;
        check1("z_ld_valid", rsp_valid_z, 1'b1);
        check("z_ld_rdata", rsp_rdata_z, 32'h1234_5678);
        rsp_ready_z = 1'b1;
        @(negedge clk);
        rsp_ready_z = 1'b0;

        // Three wait states: reset one cycle after a store accept abandons it.
        check1("t_ready", req_ready_t, 1'b1);
        req_valid_t = 1'b1; req_write_t = 1'b1; req_addr_t = 32'd12; req_wdata_t = 32'h0000_00C3;
        @(negedge clk);
        req_valid_t = 1'b0; reset_t = 1'b1;
        check1("t_wait_valid", rsp_valid_t, 1'b0);
        @(negedge clk);
        reset_t = 1'b0;
        repeat (6) begin
            check1("t_no_rsp", rsp_valid_t, 1'b0);
            check1("t_ready_idle", req_ready_t, 1'b1);
            check("t_dm_12", {24'b0, dm_12_t}, 32'h0);
            check("t_dm_4", {24'b0, dm_4_t}, 32'h0);
            @(negedge clk);
        end
        req_valid_t = 1'b1; req_write_t = 1'b0;
        @(negedge clk);
        req_valid_t = 1'b0;
        n = 1;
        while (!rsp_valid_t && n < 50) begin @(negedge clk); n++; end
        check("t_ld_latency", 32'(n), 32'd4);
        check("t_ld_rdata", rsp_rdata_t, 32'h0);
        check1("t_ld_err", rsp_err_t, 1'b0);
        rsp_ready_t = 1'b1;
        @(negedge clk);
        rsp_ready_t = 1'b0;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
